// File: rtl/hazard_if.sv
// hazard_if: decode/pipeline <-> hazard controller signal bundle.
//  master : pipeline side, drives stage addresses/enables, receives controls.
//  slave  : hazard controller side.
//  D-stage  : A1D, A2D, tuse_rs, tuse_rt, md_useD
//  E/M/W    : A3E/M/W, RegWriteE/M/W, res_E, res_M
//  MDU      : md_startE, md_divE -> md_busy, md_done
//  Controls : stallF, stallD, flushE, fwd_rsD/rtD/rsE/rtE, fwd_rtM
interface hazard_if;
  logic [4:0] A1D, A2D;
  logic [1:0] tuse_rs, tuse_rt;
  logic       md_useD;
  logic [4:0] A3E, A3M, A3W;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [1:0] res_E, res_M;
  logic       md_startE, md_divE;
  logic       stallF, stallD, flushE;
  logic [1:0] fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;
  logic       fwd_rtM;
  logic       md_busy, md_done;

  modport master (
    output A1D, A2D, tuse_rs, tuse_rt, md_useD,
    output A3E, A3M, A3W, RegWriteE, RegWriteM, RegWriteW, res_E, res_M,
    output md_startE, md_divE,
    input  stallF, stallD, flushE, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, fwd_rtM,
    input  md_busy, md_done
  );

  modport slave (
    input  A1D, A2D, tuse_rs, tuse_rt, md_useD,
    input  A3E, A3M, A3W, RegWriteE, RegWriteM, RegWriteW, res_E, res_M,
    input  md_startE, md_divE,
    output stallF, stallD, flushE, fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE, fwd_rtM,
    output md_busy, md_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward sequencing for the 5-stage pipeline plus
// the multi-cycle MDU busy tracker.
//  clk, rst_n : clock (rising), asynchronous active-low reset
//  hz         : hazard_if.slave bundle (see hazard_if.sv for signal list)
// Stall/flush and forward selects are combinational on the current inputs;
// the E-stage rs/rt, M-stage rt and MDU state are registered here.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES - 1);

  // Tnew of the producer in each stage
  logic [1:0] tnew_e;
  logic       tnew_m;
  always_comb begin
    case (hz.res_E)
      2'b01:   tnew_e = 2'd1;
      2'b10:   tnew_e = 2'd2;
      default: tnew_e = 2'd0;
    endcase
  end
  assign tnew_m = (hz.res_M == 2'b10);

  // A stage can only be a producer when it writes a nonzero register
  logic vld_e, vld_m, vld_w;
  assign vld_e = hz.RegWriteE && (hz.A3E != 5'd0);
  assign vld_m = hz.RegWriteM && (hz.A3M != 5'd0);
  assign vld_w = hz.RegWriteW && (hz.A3W != 5'd0);

  // Source operands: index 0 = rs, 1 = rt
  logic [1:0][4:0] a_d, a_e;
  logic [1:0][1:0] tuse;
  logic [1:0][1:0] fwd_d, fwd_e;
  logic [1:0]      data_stall_v;
  logic [4:0]      rt_m;

  assign a_d  = {hz.A2D, hz.A1D};
  assign tuse = {hz.tuse_rt, hz.tuse_rs};

  for (genvar i = 0; i < 2; i++) begin : g_src
    logic hit_e, hit_m, hit_w, ex_m, ex_w;
    assign hit_e = vld_e && (a_d[i] == hz.A3E);
    assign hit_m = vld_m && (a_d[i] == hz.A3M);
    assign hit_w = vld_w && (a_d[i] == hz.A3W);
    // tuse==3 (not read) is never below a Tnew of at most 2
    assign data_stall_v[i] = (hit_e && (tuse[i] < tnew_e)) ||
                             (hit_m && (tuse[i] < {1'b0, tnew_m}));
    assign fwd_d[i] = (hit_e && tnew_e == 2'd0) ? 2'd1 :
                      (hit_m && !tnew_m)        ? 2'd2 :
                      hit_w                     ? 2'd3 : 2'd0;
    // E-stage operands look one stage further down the pipe
    assign ex_m = vld_m && (a_e[i] == hz.A3M);
    assign ex_w = vld_w && (a_e[i] == hz.A3W);
    assign fwd_e[i] = (ex_m && !tnew_m) ? 2'd2 :
                      ex_w              ? 2'd3 : 2'd0;
  end

  // MDU tracker
  typedef enum logic {IDLE, BUSY} md_state_t;
  md_state_t        state;
  logic [CNT_W-1:0] count;
  logic             md_busy_q, md_done_q;

  logic md_stall, stall;
  assign md_stall = hz.md_useD && (md_busy_q || hz.md_startE);
  assign stall    = (|data_stall_v) || md_stall;

  assign hz.stallF  = stall;
  assign hz.stallD  = stall;
  assign hz.flushE  = stall;
  assign hz.fwd_rsD = fwd_d[0];
  assign hz.fwd_rtD = fwd_d[1];
  assign hz.fwd_rsE = fwd_e[0];
  assign hz.fwd_rtE = fwd_e[1];
  assign hz.fwd_rtM = vld_w && (rt_m == hz.A3W);
  assign hz.md_busy = md_busy_q;
  assign hz.md_done = md_done_q;

  // E-stage bubble on stall; the M stage never holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_e  <= '0;
      rt_m <= '0;
    end else begin
      a_e  <= stall ? '0 : a_d;
      rt_m <= a_e[1];
    end
  end

  // done is registered alongside the count so it is high exactly while
  // BUSY holds count==0; a start (even while busy) reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else if (hz.md_startE) begin
      state     <= BUSY;
      count     <= hz.md_divE ? DIV_LD : MULT_LD;
      md_busy_q <= 1'b1;
      md_done_q <= hz.md_divE ? (DIV_LD == '0) : (MULT_LD == '0);
    end else begin
      case (state)
        BUSY: begin
          if (count == '0) begin
            state     <= IDLE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b0;
          end else begin
            count     <= count - 1'b1;
            md_done_q <= (count == CNT_W'(1));
          end
        end
        default: begin
          md_busy_q <= 1'b0;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_if hif();
  hazard_ctrl #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hif)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: what register each later stage holds, and how many
  // MDU cycles remain (including the current one).
  int m_rsE, m_rtE, m_rtM, m_left;

  function automatic int tn_e();
    case (hif.res_E)
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 0;
    endcase
  endfunction
  function automatic int tn_m();
    return (hif.res_M == 2'b10) ? 1 : 0;
  endfunction
  function automatic bit hit(input int a, input int d, input logic we);
    return (we === 1'b1) && (d != 0) && (a == d);
  endfunction
  function automatic bit src_stall(input int a, input int tu);
    return (hit(a, int'(hif.A3E), hif.RegWriteE) && tu < tn_e()) ||
           (hit(a, int'(hif.A3M), hif.RegWriteM) && tu < tn_m());
  endfunction
  function automatic bit exp_stall();
    return src_stall(int'(hif.A1D), int'(hif.tuse_rs)) ||
           src_stall(int'(hif.A2D), int'(hif.tuse_rt)) ||
           (hif.md_useD && (m_left > 0 || hif.md_startE));
  endfunction
  function automatic int exp_fd(input int a);
    if (hit(a, int'(hif.A3E), hif.RegWriteE) && tn_e() == 0) return 1;
    if (hit(a, int'(hif.A3M), hif.RegWriteM) && tn_m() == 0) return 2;
    if (hit(a, int'(hif.A3W), hif.RegWriteW)) return 3;
    return 0;
  endfunction
  function automatic int exp_fe(input int a);
    if (hit(a, int'(hif.A3M), hif.RegWriteM) && tn_m() == 0) return 2;
    if (hit(a, int'(hif.A3W), hif.RegWriteW)) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    m_rsE = 0; m_rtE = 0; m_rtM = 0; m_left = 0;
  endtask

  task automatic clr();
    hif.A1D = 0; hif.A2D = 0; hif.tuse_rs = 2'd3; hif.tuse_rt = 2'd3;
    hif.md_useD = 0; hif.A3E = 0; hif.A3M = 0; hif.A3W = 0;
    hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
    hif.res_E = 0; hif.res_M = 0; hif.md_startE = 0; hif.md_divE = 0;
  endtask

  task automatic settle_check();
    bit st;
    #1;
    st = exp_stall();
    chk("stallF",  int'(hif.stallF), int'(st));
    chk("stallD",  int'(hif.stallD), int'(st));
    chk("flushE",  int'(hif.flushE), int'(st));
    chk("fwd_rsD", int'(hif.fwd_rsD), exp_fd(int'(hif.A1D)));
    chk("fwd_rtD", int'(hif.fwd_rtD), exp_fd(int'(hif.A2D)));
    chk("fwd_rsE", int'(hif.fwd_rsE), exp_fe(m_rsE));
    chk("fwd_rtE", int'(hif.fwd_rtE), exp_fe(m_rtE));
    chk("fwd_rtM", int'(hif.fwd_rtM), int'(hit(m_rtM, int'(hif.A3W), hif.RegWriteW)));
    chk("md_busy", int'(hif.md_busy), int'(m_left > 0));
    chk("md_done", int'(hif.md_done), int'(m_left == 1));
  endtask

  task automatic adv();
    bit st;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      st = exp_stall();
      m_rtM = m_rtE;
      m_rsE = st ? 0 : int'(hif.A1D);
      m_rtE = st ? 0 : int'(hif.A2D);
      if (hif.md_startE) m_left = hif.md_divE ? DIV : MULT;
      else if (m_left > 0) m_left--;
    end
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(5))
      0: return 5'd0;
      1: return 5'd1;
      2: return 5'd2;
      3: return 5'd3;
      4: return 5'd31;
      default: return 5'($urandom_range(31));
    endcase
  endfunction

  initial begin
    model_reset();
    clr();
    #3;
    chk("rst_stall", int'(hif.stallF), 0);
    chk("rst_busy",  int'(hif.md_busy), 0);
    chk("rst_fwd",   int'(hif.fwd_rsD), 0);
    @(negedge clk);
    settle_check();
    rst_n = 1'b1;
    adv();

    // lw $1 in E, D reads $1 with tuse 1
    clr(); hif.A3E = 1; hif.RegWriteE = 1; hif.res_E = 2'b10; hif.A1D = 1; hif.tuse_rs = 1;
    settle_check(); chk("t1_stall", int'(hif.stallD), 1);
    adv();
    clr(); hif.A3M = 1; hif.RegWriteM = 1; hif.res_M = 2'b10; hif.A1D = 1; hif.tuse_rs = 1;
    settle_check(); chk("t1_nostall", int'(hif.stallD), 0); chk("t1_fwdD", int'(hif.fwd_rsD), 0);
    adv();
    clr(); hif.A3W = 1; hif.RegWriteW = 1;
    settle_check(); chk("t1_fwdE", int'(hif.fwd_rsE), 3);
    adv();

    // ALU $2 in M forwards; same $2 in E overrides and stalls
    clr(); hif.A3M = 2; hif.RegWriteM = 1; hif.res_M = 2'b01; hif.A1D = 2; hif.tuse_rs = 0;
    settle_check(); chk("t2_fwdM", int'(hif.fwd_rsD), 2); chk("t2_nostall", int'(hif.stallF), 0);
    hif.A3E = 2; hif.RegWriteE = 1; hif.res_E = 2'b01;
    settle_check(); chk("t2_Ewins", int'(hif.stallF), 1);
    adv();

    // $0 never stalls or forwards
    clr(); hif.A3E = 0; hif.RegWriteE = 1; hif.res_E = 2'b10; hif.A1D = 0; hif.tuse_rs = 0;
    settle_check(); chk("t3_stall", int'(hif.stallF), 0); chk("t3_fwd", int'(hif.fwd_rsD), 0);
    adv();

    // jal in E forwards PC+8 immediately
    clr(); hif.A3E = 31; hif.RegWriteE = 1; hif.res_E = 2'b11; hif.A1D = 31; hif.tuse_rs = 0;
    settle_check(); chk("t6_fwd", int'(hif.fwd_rsD), 1); chk("t6_stall", int'(hif.stallF), 0);
    adv();

    // divide: 10 busy cycles, done on the last, md_useD stalls throughout
    clr(); hif.md_startE = 1; hif.md_divE = 1;
    settle_check(); adv();
    clr(); hif.md_useD = 1;
    for (int i = 1; i <= DIV; i++) begin
      settle_check();
      chk("t4_busy", int'(hif.md_busy), 1);
      chk("t4_stall", int'(hif.stallF), 1);
      chk("t4_done", int'(hif.md_done), int'(i == DIV));
      adv();
    end
    settle_check(); chk("t4_idle", int'(hif.md_busy), 0); chk("t4_free", int'(hif.stallF), 0);
    adv();

    // multiply aborted by reset mid-op
    clr(); hif.md_startE = 1;
    settle_check(); adv();
    clr();
    settle_check(); adv();
    settle_check(); adv();
    #2 rst_n = 1'b0;
    #1 chk("t5_busy_rst", int'(hif.md_busy), 0);
    model_reset();
    hif.md_useD = 1;
    settle_check(); chk("t5_nostall", int'(hif.stallF), 0);
    adv();
    rst_n = 1'b1;
    settle_check(); chk("t5_after", int'(hif.stallF), 0);
    adv();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      hif.A1D = pick_reg(); hif.A2D = pick_reg();
      hif.tuse_rs = 2'($urandom_range(3)); hif.tuse_rt = 2'($urandom_range(3));
      hif.A3E = pick_reg(); hif.A3M = pick_reg(); hif.A3W = pick_reg();
      hif.RegWriteE = 1'($urandom_range(1)); hif.RegWriteM = 1'($urandom_range(1));
      hif.RegWriteW = 1'($urandom_range(1));
      hif.res_E = 2'($urandom_range(3)); hif.res_M = 2'($urandom_range(3));
      hif.md_useD = ($urandom_range(3) == 0);
      hif.md_startE = (m_left > 0) ? ($urandom_range(39) == 0) : ($urandom_range(5) == 0);
      hif.md_divE = 1'($urandom_range(1));
      settle_check();
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
